// File: rtl/icache_fill_pkg.sv
// Shared types and constants for the instruction cache fill path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_fill_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;

  // Fill FSM encoding; values are visible on debug taps, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  // Instruction presented to fetch whenever there is no hit.
  localparam logic [DATA_W-1:0] MISS_BUBBLE = 16'h0000;

  // Word address of the first word of the line containing a.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & 16'hFFFC;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache, combinational read.
// Latency: read 0 cycles; writes and flush take effect at the next edge.
// Backpressure: none, every write is accepted; flush overrides a same-cycle valid set.
module icache_line_store
  import icache_fill_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = LINE_WORDS,
  parameter int IDXW  = $clog2(LINES),
  parameter int TAGW  = ADDR_W - 2 - IDXW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDXW-1:0]   rd_idx_i,
  input  logic [1:0]        rd_off_i,
  output logic              rd_valid_o,
  output logic [TAGW-1:0]   rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_word_en_i,
  input  logic [IDXW-1:0]   wr_idx_i,
  input  logic [1:0]        wr_off_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              tag_wr_en_i,
  input  logic [TAGW-1:0]   tag_wr_tag_i,
  input  logic              tag_wr_valid_i,
  input  logic              flush_i
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  // Valid bits: reset and flush clear every line; flush beats a completing fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (tag_wr_en_i) begin
      valid_q[wr_idx_i] <= tag_wr_valid_i;
    end
  end

  // Tag and data payload: not reset, only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_word_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (tag_wr_en_i) begin
      tag_q[wr_idx_i] <= tag_wr_tag_i;
    end
  end

  // Combinational read port used for the same-cycle hit path.
  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_tag_o   = tag_q[rd_idx_i];
    rd_data_o  = data_q[rd_idx_i][rd_off_i];
  end

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped I-cache front end: hit lookup for fetch, miss FSM, 4-word line fill.
// Latency: hit 0 cycles; miss stalls fetch through REQ, the grant wait and the full burst.
// Backpressure: o_stall holds fetch on a miss; o_mem_req held until i_mem_gnt; fill waits on i_mem_vld.
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd_req,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_vld,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [15:0]       o_miss_cnt
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = ADDR_W - 2 - IDXW;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              poison_q, poison_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [IDXW-1:0]   lk_idx, fill_idx;
  logic [TAGW-1:0]   lk_tag, fill_tag, rd_tag;
  logic [1:0]        lk_off;
  logic              rd_valid, hit;
  logic [DATA_W-1:0] rd_data;
  logic              word_wr, line_done;

  // Address split for the fetch lookup and for the latched fill target.
  always_comb begin
    lk_off   = i_addr[1:0];
    lk_idx   = i_addr[IDXW+1:2];
    lk_tag   = i_addr[ADDR_W-1:IDXW+2];
    fill_idx = addr_q[IDXW+1:2];
    fill_tag = addr_q[ADDR_W-1:IDXW+2];
  end

  icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDXW  (IDXW),
    .TAGW  (TAGW)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .rd_idx_i       (lk_idx),
    .rd_off_i       (lk_off),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_data_o      (rd_data),
    .wr_word_en_i   (word_wr),
    .wr_idx_i       (fill_idx),
    .wr_off_i       (cnt_q),
    .wr_data_i      (i_mem_data),
    .tag_wr_en_i    (line_done),
    .tag_wr_tag_i   (fill_tag),
    .tag_wr_valid_i (~poison_q & ~i_flush),
    .flush_i        (i_flush)
  );

  // Fetch-side outputs and fill write strobes; hits only count while idle.
  always_comb begin
    hit        = rd_valid & (rd_tag == lk_tag) & (state_q == ST_IDLE);
    o_instr    = hit ? rd_data : MISS_BUBBLE;
    o_stall    = i_rd_req & ~hit;
    o_mem_req  = (state_q == ST_REQ);
    o_mem_addr = addr_q;
    o_miss_cnt = miss_cnt_q;
    word_wr    = (state_q == ST_FILL) & i_mem_vld;
    line_done  = word_wr & (cnt_q == 2'd3);
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      poison_q   <= 1'b0;
      addr_q     <= '0;
      miss_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poison_q   <= poison_d;
      addr_q     <= addr_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Miss FSM: latch line, request, then absorb exactly four words.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poison_d   = poison_q;
    addr_d     = addr_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rd_req && !hit) begin
          addr_d     = line_base(i_addr);
          miss_cnt_d = miss_cnt_q + 16'd1;
          poison_d   = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_flush) poison_d = 1'b1;
        if (i_mem_gnt) begin
          cnt_d   = 2'd0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        // A flush seen mid-burst still lets the burst drain, but the line stays invalid.
        if (i_flush) poison_d = 1'b1;
        if (i_mem_vld) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            poison_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: vector table for hit reads plus scripted miss bursts.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: memory side scripted: grant delay, 1-cycle access latency, optional vld gaps.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_rd_req;
  logic        i_flush;
  logic [15:0] o_instr;
  logic        o_stall;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_vld;
  logic [15:0] i_mem_data;
  logic [15:0] o_miss_cnt;

  int checks = 0;
  int errors = 0;
  int exp_miss = 0;

  icache_fill #(.LINES(8), .WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_rd_req   (i_rd_req),
    .i_flush    (i_flush),
    .o_instr    (o_instr),
    .o_stall    (o_stall),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_gnt  (i_mem_gnt),
    .i_mem_vld  (i_mem_vld),
    .i_mem_data (i_mem_data),
    .o_miss_cnt (o_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        req;
    logic        stall;
    logic [15:0] instr;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One fetch cycle with no memory activity; ends just after the following posedge.
  task automatic rd(input string name, input logic [15:0] addr, input logic req,
                    input logic stall, input logic [15:0] instr);
    i_addr   = addr;
    i_rd_req = req;
    @(negedge clk);
    check({name, "_stall"}, 16'(o_stall), 16'(stall));
    check({name, "_instr"}, o_instr, instr);
    next();
  endtask

  // Full miss: detect, REQ for gnt_dly+1 cycles, 1 access-latency cycle, then
  // 4 beats base+0..3 with 'gap' idle cycles between beats. Ends at the re-lookup cycle.
  task automatic run_miss(input string name, input logic [15:0] addr, input logic [15:0] base,
                          input int gnt_dly, input int gap, input int flush_beat,
                          input logic redirect, input logic [15:0] redir_addr);
    int stalls;
    logic [15:0] la;
    la = addr & 16'hFFFC;
    i_addr = addr; i_rd_req = 1'b1; i_mem_gnt = 1'b0; i_mem_vld = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    check({name, "_detect_stall"}, 16'(o_stall), 16'd1);
    check({name, "_detect_req"}, 16'(o_mem_req), 16'd0);
    stalls = 1;
    exp_miss++;
    for (int d = 0; d <= gnt_dly; d++) begin
      next();
      i_mem_gnt = (d == gnt_dly);
      @(negedge clk);
      check({name, "_req"}, 16'(o_mem_req), 16'd1);
      check({name, "_req_addr"}, o_mem_addr, la);
      if (o_stall) stalls++;
      if (d == 0) check({name, "_miss_cnt"}, o_miss_cnt, 16'(exp_miss));
    end
    next();
    i_mem_gnt = 1'b0;
    @(negedge clk);
    check({name, "_req_drop"}, 16'(o_mem_req), 16'd0);
    if (o_stall) stalls++;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        for (int g = 0; g < gap; g++) begin
          next();
          i_mem_vld = 1'b0; i_flush = 1'b0;
          @(negedge clk);
          if (o_stall) stalls++;
        end
      end
      next();
      i_mem_vld  = 1'b1;
      i_mem_data = base + 16'(k);
      i_flush    = (k == flush_beat);
      if (redirect) i_addr = redir_addr;
      @(negedge clk);
      if (o_stall) stalls++;
    end
    next();
    i_mem_vld = 1'b0; i_flush = 1'b0; i_mem_data = 16'h0000;
    check({name, "_stall_cycles"}, 16'(stalls), 16'(3 + gnt_dly + 4 + 3 * gap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0010, 1'b1, 1'b0, 16'hA000};
    tbl[1] = '{16'h0011, 1'b1, 1'b0, 16'hA001};
    tbl[2] = '{16'h0012, 1'b1, 1'b0, 16'hA002};
    tbl[3] = '{16'h0013, 1'b1, 1'b0, 16'hA003};
    tbl[4] = '{16'h0200, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{16'h0012, 1'b0, 1'b0, 16'hA002};

    // Reset state, sampled while reset is held.
    rst = 1'b1; i_addr = 16'h0013; i_rd_req = 1'b1; i_flush = 1'b0;
    i_mem_gnt = 1'b0; i_mem_vld = 1'b0; i_mem_data = 16'h0000;
    #2;
    check("rst_stall", 16'(o_stall), 16'd1);
    check("rst_mem_req", 16'(o_mem_req), 16'd0);
    check("rst_mem_addr", o_mem_addr, 16'h0000);
    check("rst_miss_cnt", o_miss_cnt, 16'h0000);
    check("rst_instr", o_instr, 16'h0000);
    next();
    rst = 1'b0; i_rd_req = 1'b0;

    // Cold miss: 7 stall cycles, then hit on offset 3.
    run_miss("cold", 16'h0013, 16'hA000, 0, 0, -1, 1'b0, 16'h0);
    rd("cold_relook", 16'h0013, 1'b1, 1'b0, 16'hA003);
    check("cold_miss_cnt", o_miss_cnt, 16'd1);

    // Hit sweep and rd_req=0 vectors.
    for (int i = 0; i < 6; i++) begin
      rd($sformatf("vec%0d", i), tbl[i].addr, tbl[i].req, tbl[i].stall, tbl[i].instr);
    end
    check("sweep_miss_cnt", o_miss_cnt, 16'd1);

    // Conflict eviction on index 4.
    run_miss("conf_a", 16'h0110, 16'hB000, 0, 0, -1, 1'b0, 16'h0);
    rd("conf_a_hit", 16'h0110, 1'b1, 1'b0, 16'hB000);
    run_miss("conf_b", 16'h0010, 16'hC000, 0, 0, -1, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) rd("conf_b_hit", 16'h0010 + 16'(k), 1'b1, 1'b0, 16'hC000 + 16'(k));
    check("conf_miss_cnt", o_miss_cnt, 16'd3);

    // Slow memory: grant after 3 extra cycles, 2-cycle gaps between beats.
    run_miss("slow", 16'h0022, 16'hD000, 3, 2, -1, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) rd("slow_hit", 16'h0020 + 16'(k), 1'b1, 1'b0, 16'hD000 + 16'(k));
    check("slow_miss_cnt", o_miss_cnt, 16'd4);

    // Flush on beat 2, then flush on the completing beat; each refill must miss again.
    run_miss("flush_b1", 16'h0030, 16'hF000, 0, 0, 1, 1'b0, 16'h0);
    run_miss("flush_b3", 16'h0030, 16'hF100, 0, 0, 3, 1'b0, 16'h0);
    run_miss("flush_ok", 16'h0030, 16'hF200, 0, 0, -1, 1'b0, 16'h0);
    rd("flush_hit", 16'h0031, 1'b1, 1'b0, 16'hF201);
    rd("flush_other_inval", 16'h0020, 1'b0, 1'b0, 16'h0000);
    check("flush_miss_cnt", o_miss_cnt, 16'd7);

    // Redirect mid-fill: old line still lands, new address then misses.
    run_miss("redir", 16'h0010, 16'hE000, 0, 0, -1, 1'b1, 16'h0040);
    run_miss("redir_new", 16'h0040, 16'h4000, 0, 0, -1, 1'b0, 16'h0);
    rd("redir_new_hit", 16'h0040, 1'b1, 1'b0, 16'h4000);
    rd("redir_old_hit", 16'h0011, 1'b1, 1'b0, 16'hE001);
    check("redir_miss_cnt", o_miss_cnt, 16'd9);

    // Reset asserted mid-FILL (two beats in).
    i_addr = 16'h0050; i_rd_req = 1'b1;
    next();
    i_mem_gnt = 1'b1;
    next();
    i_mem_gnt = 1'b0; i_mem_vld = 1'b1; i_mem_data = 16'h5000;
    next();
    i_mem_data = 16'h5001;
    next();
    rst = 1'b1; i_mem_vld = 1'b0;
    #1;
    check("midrst_mem_req", 16'(o_mem_req), 16'd0);
    check("midrst_stall", 16'(o_stall), 16'd1);
    check("midrst_miss_cnt", o_miss_cnt, 16'h0000);
    next();
    rst = 1'b0;
    rd("midrst_inval", 16'h0010, 1'b0, 1'b0, 16'h0000);
    rd("midrst_idle_miss", 16'h0010, 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    check("midrst_req_again", 16'(o_mem_req), 16'd1);
    check("midrst_req_addr", o_mem_addr, 16'h0010);
    check("midrst_cnt_restart", o_miss_cnt, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fill.md
# icache_fill

Direct-mapped instruction cache placed between main memory and the fetch stage of the 5-stage CPU. Serves 16-bit instructions to fetch in the same cycle on a hit. On a miss it stalls fetch, bursts the 4-word line in from a slow memory port, and then resumes. Also provides a flush input and a miss counter for performance debug.

## Interface
Parameters:
- LINES, 8, number of cache lines; power of 2, range 2..64.
- WORDS, 4, 16-bit words per line; fixed at 4, and the offset is 2 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_addr  in  16  fetch word address (PC).
- i_rd_req  in  1  fetch wants an instruction this cycle; low while halted.
- i_flush  in  1  invalidate every line.
- o_instr  out  16  instruction; valid when i_rd_req & ~o_stall.
- o_stall  out  1  fetch must hold PC and insert a bubble.
- o_mem_req  out  1  line-fill request to memory.
- o_mem_addr  out  16  line-aligned word address, {tag,index,2'b00}.
- i_mem_gnt  in  1  memory accepts the request this cycle.
- i_mem_vld  in  1  one fill word valid on i_mem_data.
- i_mem_data  in  16  fill word; words arrive in order, offset 0..3.
- o_miss_cnt  out  16  count of misses started; wraps at 16'hFFFF.

## Operation
- Address split: offset = i_addr[1:0]; index = i_addr[IDXW+1:2] with IDXW = log2(LINES); tag = i_addr[15:IDXW+2]. With LINES=8 the tag is 11 bits.
- Storage: valid[LINES], tag[LINES], and data[LINES][4], all in flops. The read path is combinational.
- hit = valid[index] & (tag[index] == tag) & state==IDLE.
- o_instr = data[index][offset] on a hit, else 16'h0000.
- o_stall = i_rd_req & ~hit.
- FSM states and transitions:
  - IDLE: if i_rd_req & ~hit, latch the line address, increment o_miss_cnt, and go to REQ.
  - REQ: hold o_mem_req=1 and o_mem_addr stable. When i_mem_gnt is seen, go to FILL with the word counter at 0.
  - FILL: on each i_mem_vld, write i_mem_data into data[latched index][cnt] and increment cnt (2 bits). On the vld where cnt==3, write tag, set valid (unless the fill is poisoned), and go to IDLE.
- The fill always targets the latched address. If i_addr changes mid-miss (for example a branch redirect flushes fetch), the fill still completes. The new address is then looked up in IDLE, which costs one extra cycle.
- Flush:
  - i_flush clears all valid bits at the next edge.
  - If it is asserted while in REQ or FILL, the fill is marked poisoned: the burst is consumed in full, but valid is not set at completion.
  - If flush and a fill completion happen in the same cycle, flush wins and the line stays invalid.
- i_mem_vld outside FILL is ignored. i_mem_gnt outside REQ is ignored.
- i_rd_req=0 never starts a miss and never raises o_stall.

## Timing
- Reset values:
  - valid all 0; state IDLE; cnt 0; poisoned 0.
  - o_mem_req 0, o_mem_addr 16'h0000, o_miss_cnt 16'h0000.
  - Tag and data arrays are not reset.
  - o_stall = i_rd_req during reset, since all lines are invalid.
- Hit latency is 0 cycles, combinational from i_addr.
- Miss cost is 1 (IDLE) + 1 + grant wait (REQ) + 4 + vld gaps (FILL) + 1 (IDLE re-lookup). With an immediate grant and back-to-back vld this is 7 stall cycles.
- o_mem_req rises the cycle after the miss is detected. It falls the cycle after i_mem_gnt.
- Reset asserted mid-fill aborts the burst immediately. Memory-side recovery is the memory's responsibility.
- o_miss_cnt increments exactly once per miss, on the IDLE→REQ edge.

## Structure
- The FSM state encoding (IDLE=2'd0, REQ=2'd1, FILL=2'd2) and the miss bubble value 16'h0000 go in the shared defines file, next to the opcodes.
- One sub-module, icache_line_store, holds the valid/tag/data arrays. It has a combinational read port, a word write port, a tag/valid write port, and flush-clear.
- The FSM, counters and memory port live in icache_fill.

## Test plan
- Cold miss:
  - Stimulus: after reset, i_rd_req=1, i_addr=16'h0013; gnt on the first REQ cycle; vld data 16'hA000..A003 back-to-back.
  - Response: o_mem_addr=16'h0010; o_stall high for 7 cycles; then o_instr=16'hA003 with o_stall=0; o_miss_cnt=1.
- Hit sweep:
  - Stimulus: after the cold miss, addresses 16'h0010..0013 on consecutive cycles.
  - Response: o_stall=0 each cycle; o_instr=A000..A003; o_miss_cnt stays 1.
- Conflict eviction:
  - Stimulus: fill 16'h0010, then access 16'h0110 (same index, tag differs), then 16'h0010 again.
  - Response: three misses; o_miss_cnt=3; the final data matches the memory model.
- Slow memory:
  - Stimulus: gnt delayed 3 cycles; a 2-cycle gap between vld beats.
  - Response: o_mem_req held with o_mem_addr stable; words land at offsets 0..3 in order.
- Flush during fill:
  - Stimulus: i_flush pulsed during the second FILL beat.
  - Response: the burst completes, but the line stays invalid; the next access to the same address misses again.
- Redirect mid-miss and reset:
  - Stimulus: i_addr changed to 16'h0040 during FILL of 16'h0010.
  - Response: the 16'h0010 line becomes valid; 16'h0040 then misses.
  - Stimulus: rst asserted in FILL.
  - Response: state IDLE, o_mem_req=0, all lines invalid.
